// File: rtl/vsid_inserter_if.sv
// AXI-Stream bundle used on both sides of the VSID inserter.
// The master drives payload and sideband signals, and the slave drives tready.
interface vsid_inserter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [ID_WIDTH-1:0]     tid;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, output tkeep, output tid, output tlast, output tvalid,
                  input tready);
  modport slave  (input tdata, input tkeep, input tid, input tlast, input tvalid,
                  output tready);
endinterface

// File: rtl/vsid_inserter.sv
// Egress VSID inserter: overwrites the 24-bit VXLAN/NVGRE VSID with the per-tenant table value.
// It is a single registered stage between the egress arbiter and the MAC.
module vsid_inserter #(
  parameter int unsigned AXIS_BUS_WIDTH    = 64,
  parameter int unsigned AXIS_ID_WIDTH     = 4,
  parameter int unsigned MAX_PACKET_LENGTH = 1522,
  parameter int unsigned MAX_ADDED_OFFSET  = 64,
  localparam int unsigned NUM_BUS_BYTES    = AXIS_BUS_WIDTH / 8,
  localparam int unsigned NUM_AXIS_ID      = 2 ** AXIS_ID_WIDTH,
  localparam int unsigned BEAT_W           = $clog2(MAX_PACKET_LENGTH / NUM_BUS_BYTES + 2),
  localparam int unsigned OFS_W            = $clog2(MAX_ADDED_OFFSET + 1)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  vsid_inserter_if.slave           axis_in,
  vsid_inserter_if.master          axis_out,
  input  logic                     is_vxlan,
  input  logic [OFS_W-1:0]         added_offset,
  input  logic [23:0]              vsids          [NUM_AXIS_ID],
  input  logic                     vsid_insert_en [NUM_AXIS_ID],
  output logic [31:0]              inserted_count
);

  localparam logic [BEAT_W-1:0] BeatMax = {BEAT_W{1'b1}};

  logic                      first_q, first_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [AXIS_ID_WIDTH-1:0]  tid_q, tid_d;
  logic [OFS_W-1:0]          off_q, off_d;
  logic                      en_q, en_d;
  logic [31:0]               count_q, count_d;

  logic [AXIS_BUS_WIDTH-1:0] out_tdata_q, out_tdata_d;
  logic [NUM_BUS_BYTES-1:0]  out_tkeep_q, out_tkeep_d;
  logic [AXIS_ID_WIDTH-1:0]  out_tid_q, out_tid_d;
  logic                      out_tlast_q, out_tlast_d;
  logic                      out_tvalid_q, out_tvalid_d;

  logic                      accept;
  logic [AXIS_ID_WIDTH-1:0]  cur_tid;
  logic [OFS_W-1:0]          cur_off;
  logic                      cur_en;
  logic [23:0]               cur_vsid;
  logic [AXIS_BUS_WIDTH-1:0] data_mod;
  logic                      field_end;
  int unsigned               field_pos;
  int unsigned               byte_pos;

  assign axis_in.tready = ~out_tvalid_q | axis_out.tready;
  assign accept         = axis_in.tvalid & axis_in.tready;

  assign axis_out.tdata  = out_tdata_q;
  assign axis_out.tkeep  = out_tkeep_q;
  assign axis_out.tid    = out_tid_q;
  assign axis_out.tlast  = out_tlast_q;
  assign axis_out.tvalid = out_tvalid_q;
  assign inserted_count  = count_q;

  // The first beat of a packet has no latched context yet, so it uses the live inputs.
  always_comb begin
    cur_tid  = first_q ? axis_in.tid : tid_q;
    cur_off  = first_q ? added_offset : off_q;
    cur_en   = first_q ? vsid_insert_en[axis_in.tid] : en_q;
    cur_vsid = vsids[cur_tid];
  end

  always_comb begin
    data_mod  = axis_in.tdata;
    field_end = 1'b0;
    byte_pos  = 0;
    field_pos = (is_vxlan ? 32'd46 : 32'd38) + 32'(cur_off);
    for (int i = 0; i < NUM_BUS_BYTES; i++) begin
      byte_pos = 32'(beat_q) * NUM_BUS_BYTES + unsigned'(i);
      if (cur_en && axis_in.tkeep[i]) begin
        if (byte_pos == field_pos) begin
          data_mod[8*i +: 8] = cur_vsid[23:16];
        end else if (byte_pos == field_pos + 32'd1) begin
          data_mod[8*i +: 8] = cur_vsid[15:8];
        end else if (byte_pos == field_pos + 32'd2) begin
          data_mod[8*i +: 8] = cur_vsid[7:0];
          field_end          = 1'b1;
        end
      end
    end
  end

  always_comb begin
    first_d      = first_q;
    beat_d       = beat_q;
    tid_d        = tid_q;
    off_d        = off_q;
    en_d         = en_q;
    count_d      = count_q;
    out_tdata_d  = out_tdata_q;
    out_tkeep_d  = out_tkeep_q;
    out_tid_d    = out_tid_q;
    out_tlast_d  = out_tlast_q;
    out_tvalid_d = out_tvalid_q;
    if (accept) begin
      out_tdata_d  = data_mod;
      out_tkeep_d  = axis_in.tkeep;
      out_tid_d    = axis_in.tid;
      out_tlast_d  = axis_in.tlast;
      out_tvalid_d = 1'b1;
      if (field_end) begin
        count_d = count_q + 32'd1;
      end
      if (first_q) begin
        tid_d   = axis_in.tid;
        off_d   = added_offset;
        en_d    = vsid_insert_en[axis_in.tid];
        first_d = 1'b0;
      end
      if (axis_in.tlast) begin
        first_d = 1'b1;
        beat_d  = '0;
      end else if (beat_q != BeatMax) begin
        beat_d = beat_q + 1'b1;
      end
    end else if (axis_out.tready) begin
      out_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      first_q      <= 1'b1;
      beat_q       <= '0;
      tid_q        <= '0;
      off_q        <= '0;
      en_q         <= 1'b0;
      count_q      <= '0;
      out_tdata_q  <= '0;
      out_tkeep_q  <= '0;
      out_tid_q    <= '0;
      out_tlast_q  <= 1'b0;
      out_tvalid_q <= 1'b0;
    end else begin
      first_q      <= first_d;
      beat_q       <= beat_d;
      tid_q        <= tid_d;
      off_q        <= off_d;
      en_q         <= en_d;
      count_q      <= count_d;
      out_tdata_q  <= out_tdata_d;
      out_tkeep_q  <= out_tkeep_d;
      out_tid_q    <= out_tid_d;
      out_tlast_q  <= out_tlast_d;
      out_tvalid_q <= out_tvalid_d;
    end
  end

endmodule

// File: tb/tb_vsid_inserter.sv
// Directed and randomized-handshake bench for vsid_inserter.
// A 64-bit bus and 16 tenants are used.
module tb_vsid_inserter;
  localparam int W   = 64;
  localparam int NB  = 8;
  localparam int IDW = 4;
  localparam int NID = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  vsid_inserter_if #(.DATA_WIDTH(W), .ID_WIDTH(IDW)) in_if ();
  vsid_inserter_if #(.DATA_WIDTH(W), .ID_WIDTH(IDW)) out_if ();

  logic        is_vxlan;
  logic [6:0]  added_offset;
  logic [23:0] vsids [NID];
  logic        en    [NID];
  logic [31:0] inserted_count;

  vsid_inserter #(
    .AXIS_BUS_WIDTH   (W),
    .AXIS_ID_WIDTH    (IDW),
    .MAX_PACKET_LENGTH(1522),
    .MAX_ADDED_OFFSET (64)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .axis_in       (in_if),
    .axis_out      (out_if),
    .is_vxlan      (is_vxlan),
    .added_offset  (added_offset),
    .vsids         (vsids),
    .vsid_insert_en(en),
    .inserted_count(inserted_count)
  );

  int passed = 0;
  int total  = 0;
  int stall_viol = 0;
  int exp_cnt = 0;
  bit rand_rdy = 0;
  bit rand_vld = 0;

  logic [7:0]  pkt [256];
  logic [63:0] exp_data [$];
  logic [7:0]  exp_keep [$];
  logic        exp_last [$];
  logic [3:0]  exp_tid  [$];
  logic [63:0] mon_data [$];
  logic [7:0]  mon_keep [$];
  logic        mon_last [$];
  logic [3:0]  mon_tid  [$];

  always @(negedge aclk) out_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

  // Samples one time unit before each rising edge, when all signals are settled.
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;
  logic [3:0]  prev_tid;
  bit          prev_stall = 0;
  always @(negedge aclk) begin
    #4;
    if (!aresetn) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (out_if.tvalid !== 1'b1 || out_if.tdata !== prev_data ||
                         out_if.tkeep !== prev_keep || out_if.tlast !== prev_last ||
                         out_if.tid !== prev_tid)) stall_viol++;
      if (out_if.tvalid && out_if.tready) begin
        mon_data.push_back(out_if.tdata);
        mon_keep.push_back(out_if.tkeep);
        mon_last.push_back(out_if.tlast);
        mon_tid.push_back(out_if.tid);
      end
      prev_stall = out_if.tvalid && !out_if.tready;
      prev_data  = out_if.tdata;
      prev_keep  = out_if.tkeep;
      prev_last  = out_if.tlast;
      prev_tid   = out_if.tid;
    end
  end

  task automatic clear_queues();
    exp_data.delete(); exp_keep.delete(); exp_last.delete(); exp_tid.delete();
    mon_data.delete(); mon_keep.delete(); mon_last.delete(); mon_tid.delete();
  endtask

  // Must be entered at a falling edge; returns at the falling edge after acceptance.
  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [3:0] t);
    int waited = 0;
    bit acc = 0;
    if (rand_vld) begin
      while ($urandom_range(0, 1) != 0) begin
        in_if.tvalid = 1'b0;
        @(negedge aclk);
      end
    end
    in_if.tdata  = d;
    in_if.tkeep  = k;
    in_if.tlast  = l;
    in_if.tid    = t;
    in_if.tvalid = 1'b1;
    while (!acc) begin
      #4;
      acc = in_if.tready;
      @(negedge aclk);
      waited++;
      if (!acc && waited > 500) begin
        $display("FAIL accept_timeout: tready=%b after %0d cycles, required 1", in_if.tready,
                 waited);
        $fatal(1, "input beat never accepted");
      end
    end
    in_if.tvalid = 1'b0;
  endtask

  // Builds the expected beats from a packet-level model, then streams pkt[0:len-1].
  task automatic send_pkt(input int len, input logic [3:0] t, input logic [6:0] off);
    logic [7:0]  ep [256];
    logic [63:0] d, ed;
    logic [7:0]  k;
    int f, nb, p;
    added_offset = off;
    for (int i = 0; i < len; i++) ep[i] = pkt[i];
    f = (is_vxlan ? 46 : 38) + int'(off);
    if (en[t]) begin
      for (int j = 0; j < 3; j++) if (f + j < len) ep[f + j] = vsids[t][23 - 8 * j -: 8];
      if (f + 2 < len) exp_cnt++;
    end
    nb = (len + NB - 1) / NB;
    for (int b = 0; b < nb; b++) begin
      d = '0; ed = '0; k = '0;
      for (int i = 0; i < NB; i++) begin
        p = b * NB + i;
        if (p < len) begin
          d[8*i +: 8]  = pkt[p];
          ed[8*i +: 8] = ep[p];
          k[i]         = 1'b1;
        end
      end
      exp_data.push_back(ed);
      exp_keep.push_back(k);
      exp_last.push_back(b == nb - 1);
      exp_tid.push_back(t);
      drive_beat(d, k, b == nb - 1, t);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge aclk);
      #4;
      n++;
    end while (out_if.tvalid && n < 1000);
    if (out_if.tvalid) begin
      $display("FAIL drain_timeout: tvalid=%b after %0d cycles, required 0", out_if.tvalid, n);
      $fatal(1, "output never drained");
    end
    @(negedge aclk);
  endtask

  task automatic fill_pkt(input logic [7:0] v);
    for (int i = 0; i < 256; i++) pkt[i] = v;
  endtask

  task automatic test_reset();
    in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tkeep = '0; in_if.tlast = 1'b0; in_if.tid = '0;
    is_vxlan = 1'b1;
    added_offset = '0;
    for (int i = 0; i < NID; i++) begin
      vsids[i] = {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)};
      en[i]    = (i % 2 == 0);
    end
    vsids[2] = 24'hABCDEF;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    total++; if (out_if.tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", out_if.tvalid); else passed++;
    total++; if (inserted_count !== 32'd0) $display("FAIL reset_count: got %0d want 0", inserted_count); else passed++;
    total++; if (out_if.tdata !== 64'd0) $display("FAIL reset_tdata: got %h want 0", out_if.tdata); else passed++;
    total++; if (out_if.tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", out_if.tlast); else passed++;
    total++; if (in_if.tready !== 1'b1) $display("FAIL reset_tready: got %b want 1", in_if.tready); else passed++;
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_vxlan();
    logic [7:0] want, got;
    clear_queues();
    fill_pkt(8'h00);
    send_pkt(64, 4'd2, 7'd0);
    wait_drain();
    total++; if (mon_data.size() != 8) $display("FAIL vxlan_beats: got %0d want 8", mon_data.size()); else passed++;
    if (mon_data.size() == 8) begin
      for (int p = 0; p < 64; p++) begin
        want = (p == 46) ? 8'hAB : (p == 47) ? 8'hCD : (p == 48) ? 8'hEF : 8'h00;
        got  = mon_data[p / 8][8 * (p % 8) +: 8];
        total++; if (got !== want) $display("FAIL vxlan_byte%0d: got %h want %h", p, got, want); else passed++;
      end
      total++; if (mon_last[7] !== 1'b1 || mon_keep[7] !== 8'hFF || mon_tid[7] !== 4'd2)
        $display("FAIL vxlan_side: got last=%b keep=%h tid=%0d want 1 ff 2", mon_last[7], mon_keep[7], mon_tid[7]);
      else passed++;
    end
    total++; if (inserted_count !== 32'd1) $display("FAIL vxlan_count: got %0d want 1", inserted_count); else passed++;
  endtask

  task automatic test_nvgre_offset();
    logic [7:0] want, got;
    clear_queues();
    is_vxlan = 1'b0;
    fill_pkt(8'h00);
    send_pkt(64, 4'd2, 7'd0);
    wait_drain();
    total++; if (mon_data.size() != 8) $display("FAIL nvgre_beats: got %0d want 8", mon_data.size()); else passed++;
    if (mon_data.size() == 8) begin
      for (int p = 36; p < 42; p++) begin
        want = (p == 38) ? 8'hAB : (p == 39) ? 8'hCD : (p == 40) ? 8'hEF : 8'h00;
        got  = mon_data[p / 8][8 * (p % 8) +: 8];
        total++; if (got !== want) $display("FAIL nvgre_byte%0d: got %h want %h", p, got, want); else passed++;
      end
    end
    total++; if (inserted_count !== 32'd2) $display("FAIL nvgre_count: got %0d want 2", inserted_count); else passed++;
    clear_queues();
    is_vxlan = 1'b1;
    send_pkt(64, 4'd2, 7'd4);
    wait_drain();
    total++; if (mon_data.size() != 8) $display("FAIL off4_beats: got %0d want 8", mon_data.size()); else passed++;
    if (mon_data.size() == 8) begin
      for (int p = 45; p < 54; p++) begin
        want = (p == 50) ? 8'hAB : (p == 51) ? 8'hCD : (p == 52) ? 8'hEF : 8'h00;
        got  = mon_data[p / 8][8 * (p % 8) +: 8];
        total++; if (got !== want) $display("FAIL off4_byte%0d: got %h want %h", p, got, want); else passed++;
      end
    end
    total++; if (inserted_count !== 32'd3) $display("FAIL off4_count: got %0d want 3", inserted_count); else passed++;
  endtask

  task automatic test_disabled();
    int bad = 0;
    clear_queues();
    fill_pkt(8'h5A);
    en[2] = 1'b0;
    send_pkt(64, 4'd2, 7'd0);
    wait_drain();
    en[2] = 1'b1;
    send_pkt(64, 4'd3, 7'd0);
    wait_drain();
    total++; if (mon_data.size() != 16) $display("FAIL dis_beats: got %0d want 16", mon_data.size()); else passed++;
    for (int b = 0; b < mon_data.size(); b++) if (mon_data[b] !== 64'h5A5A5A5A5A5A5A5A) bad++;
    total++; if (bad != 0) $display("FAIL dis_data: got %0d altered beats want 0", bad); else passed++;
    total++; if (inserted_count !== 32'd3) $display("FAIL dis_count: got %0d want 3", inserted_count); else passed++;
  endtask

  task automatic test_short();
    clear_queues();
    fill_pkt(8'h00);
    send_pkt(47, 4'd2, 7'd0);
    wait_drain();
    total++; if (mon_data.size() != 6) $display("FAIL short_beats: got %0d want 6", mon_data.size()); else passed++;
    if (mon_data.size() == 6) begin
      total++; if (mon_data[5] !== 64'h00AB_0000_0000_0000) $display("FAIL short_last_data: got %h want 00ab000000000000", mon_data[5]); else passed++;
      total++; if (mon_keep[5] !== 8'h7F || mon_last[5] !== 1'b1) $display("FAIL short_last_side: got keep=%h last=%b want 7f 1", mon_keep[5], mon_last[5]); else passed++;
    end
    total++; if (inserted_count !== 32'd3) $display("FAIL short_count: got %0d want 3", inserted_count); else passed++;
    clear_queues();
    send_pkt(64, 4'd2, 7'd0);
    wait_drain();
    if (mon_data.size() == 8) begin
      total++; if (mon_data[5][63:48] !== 16'hCDAB || mon_data[6][7:0] !== 8'hEF)
        $display("FAIL after_short_field: got %h %h want cdab ef", mon_data[5][63:48], mon_data[6][7:0]);
      else passed++;
    end else begin
      total++; $display("FAIL after_short_beats: got %0d want 8", mon_data.size());
    end
    total++; if (inserted_count !== 32'd4) $display("FAIL after_short_count: got %0d want 4", inserted_count); else passed++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    int len;
    logic [3:0] t;
    clear_queues();
    exp_cnt = 0;
    stall_viol = 0;
    rand_rdy = 1;
    rand_vld = 1;
    for (int n = 0; n < 100; n++) begin
      len = $urandom_range(40, 90);
      t   = 4'($urandom_range(0, 15));
      for (int i = 0; i < len; i++) pkt[i] = 8'($urandom);
      send_pkt(len, t, 7'($urandom_range(0, 8)));
    end
    wait_drain();
    rand_rdy = 0;
    rand_vld = 0;
    total++; if (mon_data.size() != exp_data.size()) $display("FAIL b2b_beats: got %0d want %0d", mon_data.size(), exp_data.size()); else passed++;
    if (mon_data.size() == exp_data.size()) begin
      for (int b = 0; b < exp_data.size(); b++)
        if (mon_data[b] !== exp_data[b] || mon_keep[b] !== exp_keep[b] ||
            mon_last[b] !== exp_last[b] || mon_tid[b] !== exp_tid[b]) bad++;
    end
    total++; if (bad != 0) $display("FAIL b2b_content: got %0d wrong beats want 0", bad); else passed++;
    total++; if (stall_viol != 0) $display("FAIL b2b_stable: got %0d stall changes want 0", stall_viol); else passed++;
    total++; if (inserted_count !== 32'(4 + exp_cnt)) $display("FAIL b2b_count: got %0d want %0d", inserted_count, 4 + exp_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    fill_pkt(8'h00);
    added_offset = '0;
    for (int b = 0; b < 3; b++) drive_beat(64'd0, 8'hFF, 1'b0, 4'd2);
    in_if.tdata = '0; in_if.tkeep = 8'hFF; in_if.tlast = 1'b0; in_if.tid = 4'd2;
    in_if.tvalid = 1'b1;
    aresetn = 1'b0;
    #1;
    total++; if (out_if.tvalid !== 1'b0) $display("FAIL rst_mid_tvalid: got %b want 0", out_if.tvalid); else passed++;
    total++; if (inserted_count !== 32'd0) $display("FAIL rst_mid_count: got %0d want 0", inserted_count); else passed++;
    @(negedge aclk);
    @(negedge aclk);
    total++; if (out_if.tvalid !== 1'b0) $display("FAIL rst_hold_tvalid: got %b want 0", out_if.tvalid); else passed++;
    in_if.tvalid = 1'b0;
    aresetn = 1'b1;
    @(negedge aclk);
    clear_queues();
    send_pkt(64, 4'd2, 7'd0);
    wait_drain();
    total++; if (mon_data.size() != 8) $display("FAIL rst_new_beats: got %0d want 8", mon_data.size()); else passed++;
    if (mon_data.size() == 8) begin
      total++; if (mon_data[5] !== 64'hCDAB_0000_0000_0000 || mon_data[6] !== 64'h0000_0000_0000_00EF)
        $display("FAIL rst_new_field: got %h %h want cdab000000000000 00000000000000ef", mon_data[5], mon_data[6]);
      else passed++;
    end
    total++; if (inserted_count !== 32'd1) $display("FAIL rst_new_count: got %0d want 1", inserted_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_vxlan();
    test_nvgre_offset();
    test_disabled();
    test_short();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
